// File: rtl/bullet_manager_if.sv
// Tank-control side of the bullet manager: the fire request/response handshake
// and the collision-logic clear strobe.
interface bullet_manager_if;
  logic       fire_valid;
  logic [9:0] fire_x;
  logic [9:0] fire_y;
  logic [1:0] fire_dir;
  logic       fire_ack;
  logic       fire_full;
  logic       clear_en;
  logic [3:0] clear_idx;

  modport master (
    output fire_valid, fire_x, fire_y, fire_dir, clear_en, clear_idx,
    input  fire_ack, fire_full
  );

  modport slave (
    input  fire_valid, fire_x, fire_y, fire_dir, clear_en, clear_idx,
    output fire_ack, fire_full
  );
endinterface

// File: rtl/bullet_manager.sv
// Bullet OAM table owner: spawns bullets on fire requests, advances live bullets
// once per frame during vblank and retires the ones that leave the screen.
module bullet_manager #(
  parameter int OAM_DEPTH   = 16,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int TILE_WIDTH  = 8,
  parameter int TILE_HEIGHT = 8,
  parameter int SPEED       = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_tick,
  bullet_manager_if.slave      fire_if,
  output logic [31:0]          oam_data [OAM_DEPTH],
  output logic [4:0]           active_count,
  output logic                 busy,
  output logic                 overrun
);

  localparam int          IDX_W = $clog2(OAM_DEPTH);
  localparam logic [10:0] SPD   = 11'(SPEED);
  localparam logic [10:0] X_LIM = 11'(SCREEN_W - TILE_WIDTH);
  localparam logic [10:0] Y_LIM = 11'(SCREEN_H - TILE_HEIGHT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_SPAWN  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        oam_q [OAM_DEPTH];
  logic [31:0]        oam_d [OAM_DEPTH];
  logic               ack_q, ack_d;
  logic               full_q, full_d;
  logic               overrun_q, overrun_d;
  logic               free_found_s;
  logic [IDX_W-1:0]   free_idx_s;
  logic [4:0]         cnt_s;

  function automatic logic [31:0] make_word(input logic en, input logic [9:0] x,
                                            input logic [9:0] y, input logic [1:0] dir);
    return {3'b000, en, x, y, dir, 3'b000, 1'b0, dir};
  endfunction

  // Widened to 11 bits so that off-screen tests never see a 10-bit wrap.
  function automatic logic [31:0] advance(input logic [31:0] w);
    logic [10:0] x11;
    logic [10:0] y11;
    logic [10:0] nx;
    logic [10:0] ny;
    logic        off;
    x11 = {1'b0, w[27:18]};
    y11 = {1'b0, w[17:8]};
    nx  = x11;
    ny  = y11;
    off = 1'b0;
    case (w[7:6])
      2'd0: begin off = (y11 < SPD); ny = y11 - SPD; end
      2'd1: begin nx = x11 + SPD; off = (nx > X_LIM); end
      2'd2: begin ny = y11 + SPD; off = (ny > Y_LIM); end
      2'd3: begin off = (x11 < SPD); nx = x11 - SPD; end
      default: off = 1'b0;
    endcase
    if (off) begin
      return {w[31:29], 1'b0, w[27:0]};
    end else begin
      return make_word(1'b1, nx[9:0], ny[9:0], w[7:6]);
    end
  endfunction

  // Lowest disabled slot, skipping one that is being cleared this cycle.
  always_comb begin
    free_found_s = 1'b0;
    free_idx_s   = '0;
    for (int i = OAM_DEPTH - 1; i >= 0; i--) begin
      if (!oam_q[i][28] && !(fire_if.clear_en && (fire_if.clear_idx == IDX_W'(i)))) begin
        free_found_s = 1'b1;
        free_idx_s   = IDX_W'(i);
      end else begin
        free_found_s = free_found_s;
      end
    end
  end

  // Popcount of enable bits.
  always_comb begin
    cnt_s = 5'd0;
    for (int i = 0; i < OAM_DEPTH; i++) begin
      cnt_s = cnt_s + {4'b0000, oam_q[i][28]};
    end
  end

  // Next-state, slot writes and handshake pulses.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    oam_d     = oam_q;
    ack_d     = 1'b0;
    full_d    = 1'b0;
    overrun_d = overrun_q;
    case (state_q)
      ST_IDLE: begin
        if (frame_tick) begin
          state_d = ST_UPDATE;
          idx_d   = '0;
        end else if (fire_if.fire_valid) begin
          state_d = ST_SPAWN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_UPDATE: begin
        overrun_d = overrun_q | frame_tick;
        if (oam_q[idx_q][28] && !(fire_if.clear_en && (fire_if.clear_idx == idx_q))) begin
          oam_d[idx_q] = advance(oam_q[idx_q]);
        end else begin
          oam_d[idx_q] = oam_q[idx_q];
        end
        if (idx_q == IDX_W'(OAM_DEPTH - 1)) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      ST_SPAWN: begin
        if (free_found_s) begin
          oam_d[free_idx_s] = make_word(1'b1, fire_if.fire_x, fire_if.fire_y, fire_if.fire_dir);
          ack_d             = 1'b1;
        end else begin
          full_d            = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
    // Collision clears win over any update/spawn write to the same slot.
    if (fire_if.clear_en) begin
      oam_d[fire_if.clear_idx][28] = 1'b0;
    end else begin
      oam_d[fire_if.clear_idx][28] = oam_d[fire_if.clear_idx][28];
    end
  end

  // State and table registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      ack_q     <= 1'b0;
      full_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < OAM_DEPTH; i++) begin
        oam_q[i] <= 32'h0000_0000;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ack_q     <= ack_d;
      full_q    <= full_d;
      overrun_q <= overrun_d;
      oam_q     <= oam_d;
    end
  end

  assign oam_data          = oam_q;
  assign active_count      = cnt_s;
  assign busy              = (state_q != ST_IDLE);
  assign overrun           = overrun_q;
  assign fire_if.fire_ack  = ack_q;
  assign fire_if.fire_full = full_q;

endmodule

// File: doc/bullet_manager.md
Name: bullet_manager

Overview:
- Upstream stage of the bullet sprite renderer. Owns the 16-entry bullet OAM table.
- Spawns bullets on fire requests from tank control and advances every live bullet once per frame.
- Retires bullets that leave the screen or are hit.
- Drives the OAM word array the renderer scans during active video. Updates run only inside vblank.

Parameters:
- OAM_DEPTH, 16, number of bullet slots.
- SCREEN_W, 640, visible width in pixels.
- SCREEN_H, 480, visible height in pixels.
- TILE_WIDTH, 8, bullet sprite width.
- TILE_HEIGHT, 8, bullet sprite height.
- SPEED, 4, pixels moved per frame.

Ports:
- clk  in  1  system/pixel clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- frame_tick  in  1  one-cycle pulse at start of vblank.
- fire_valid  in  1  spawn request; held high until fire_ack or fire_full.
- fire_x  in  10  spawn x (top-left).
- fire_y  in  10  spawn y.
- fire_dir  in  2  0=up, 1=right, 2=down, 3=left.
- fire_ack  out  1  one-cycle pulse: request accepted.
- fire_full  out  1  one-cycle pulse: request dropped because no free slot.
- clear_en  in  1  collision logic retires one slot this cycle.
- clear_idx  in  4  slot to retire.
- oam_data  out  32 x OAM_DEPTH  unpacked array of registered slot words.
- active_count  out  5  number of enabled slots.
- busy  out  1  high while not IDLE.
- overrun  out  1  sticky: frame_tick arrived while in UPDATE.

Behaviour:
- Slot word format:
  - [31:29]=0; [28] enable; [27:18] x; [17:8] y; [7:6] dir; [5:3] sprite row=0; [2:0] sprite col={1'b0,dir}.
- Reset (rst_n=0, async):
  - All slot words become 0.
  - FSM to IDLE.
  - fire_ack, fire_full, busy, overrun, active_count all 0.
- FSM states: IDLE, UPDATE, SPAWN.
- IDLE:
  - frame_tick -> UPDATE with slot index 0. frame_tick wins over a simultaneous fire_valid; that fire is serviced after UPDATE.
  - Else fire_valid -> SPAWN.
- UPDATE:
  - Processes one slot per cycle, index 0..OAM_DEPTH-1, so duration is exactly OAM_DEPTH cycles. Returns to IDLE after the last slot.
  - Disabled slots are untouched.
  - Enabled slot moves SPEED px in dir.
  - Retire (enable<=0, other fields kept) if the move leaves the screen:
    - up: y < SPEED.
    - left: x < SPEED.
    - right: x+SPEED > SCREEN_W-TILE_WIDTH.
    - down: y+SPEED > SCREEN_H-TILE_HEIGHT.
  - Edge case: landing exactly on x = SCREEN_W-TILE_WIDTH stays live.
  - All comparisons in 11-bit arithmetic, so there is no 10-bit wrap.
- SPAWN (1 cycle):
  - Free slot = lowest index with enable=0.
  - If one exists: write {enable=1, fire_x, fire_y, fire_dir, row 0, col dir} and pulse fire_ack in the same cycle.
  - If none: pulse fire_full and write nothing.
  - Return to IDLE either way.
  - Requester must drop fire_valid the cycle after ack/full. If it stays high, a new request is taken.
- clear_en:
  - Honoured in every state; clears enable of slot clear_idx in that cycle.
  - Has priority over an UPDATE or SPAWN write to the same slot in that cycle; SPAWN then picks the next free slot instead.
- frame_tick during UPDATE: ignored; sets overrun. overrun is cleared only by reset.
- active_count: combinational popcount of enable bits. Range 0..16.
- busy = (state != IDLE).
- oam_data: changes only on clk edges. Words are written solely by this block.

Test Plan:
- Reset, then fire at (100,200), dir=1 -> fire_ack 1 cycle after SPAWN entry; slot0 = 0x1190_C841; active_count=1.
- Slot0 from the previous case plus 3 frame_ticks -> slot0 x=112, y=200; each UPDATE lasts 16 cycles, busy high throughout.
- Fire at (0,8) dir=3 plus one frame_tick -> slot retired (enable=0); active_count decrements.
- Fire at (628,0) dir=1 -> after tick x=632 and still live; after 2nd tick retired.
- Fill 16 slots, then a 17th fire_valid -> fire_full pulse, no slot changed. Then clear_en idx=5 and fire -> spawns in slot 5.
- frame_tick and fire_valid in the same IDLE cycle -> UPDATE first, spawn in the cycle after UPDATE ends. A 2nd frame_tick mid-UPDATE -> overrun=1.
